// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, parity modes and counter-width helpers shared by the UART transmitter and receiver.
package uart_pkg;
  localparam int NB_STATE = 3;
  typedef enum logic [NB_STATE-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 0;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int NB_TICK_DEF = cnt_w(16);
  localparam int NB_BIT_DEF  = cnt_w(8);
  localparam int NB_STOP_DEF = cnt_w(4);
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: oversampling tick counter with synchronous clear; done marks the tick that ends a bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic done
);
  localparam int NB = cnt_w(OVERSAMPLE);
  logic [NB-1:0] count;
  assign done = tick & (count == NB'(OVERSAMPLE - 1));
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (tick) count <= done ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready UART transmitter (start, N_DATA bits LSB-first, optional parity, M_STOP stops).
// Define UART_TX_BREAK_EN to add i_break, which holds the idle line low between frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int N_DATA          = 8,
  parameter int PARITY_CHECK    = 1,
  parameter int EVEN_ODD_PARITY = 1,
  parameter int M_STOP          = 1,
  parameter int OVERSAMPLE      = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_start,
`ifdef UART_TX_BREAK_EN
  input  logic               i_break,
`endif
  output logic               o_ready,
  output logic               o_data,
  output logic               o_tx_done,
  output logic               o_busy
);
  localparam int NB_BIT  = cnt_w(N_DATA);
  localparam int NB_STOP = cnt_w(M_STOP);
  localparam logic [NB_BIT-1:0]  LAST_BIT  = NB_BIT'(N_DATA - 1);
  localparam logic [NB_STOP-1:0] LAST_STOP = NB_STOP'(M_STOP - 1);
  localparam logic ODD = (EVEN_ODD_PARITY == PARITY_ODD);
  state_t state;
  logic [N_DATA-1:0] shift;
  logic [NB_BIT-1:0] bit_cnt;
  logic [NB_STOP-1:0] stop_cnt;
  logic parity, bit_end, accept, brk;
`ifdef UART_TX_BREAK_EN
  assign brk = i_break;
`else
  assign brk = 1'b0;
`endif
  assign accept = i_tx_start & o_ready;
  // Holding the timer clear in IDLE means a tick in the accept cycle never counts toward START.
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk  (i_clock),
    .rst  (i_reset),
    .clear(state == IDLE),
    .tick (i_tick),
    .done (bit_end)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      o_data    <= 1'b1;
      o_ready   <= 1'b1;
      o_tx_done <= 1'b0;
      o_busy    <= 1'b0;
      shift     <= '0;
      parity    <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            shift    <= i_data[N_DATA-1:0];
            parity   <= (^i_data[N_DATA-1:0]) ^ ODD;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            o_data   <= 1'b0;
            o_ready  <= 1'b0;
            o_busy   <= 1'b1;
          end else begin
            o_data  <= ~brk;
            o_ready <= ~brk;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            o_data <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              state  <= (PARITY_CHECK != 0) ? PARITY : STOP;
              o_data <= (PARITY_CHECK != 0) ? parity : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              o_data  <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            o_data <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              state     <= IDLE;
              o_tx_done <= 1'b1;
              o_busy    <= 1'b0;
              o_ready   <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven frame checks over 8N1/8E1/8O1/7N2 instances plus multi-cycle corner sequences.
module tb_uart_tx_frame;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b1, start = 1'b0, brk = 1'b0;
  logic [7:0] data = 8'h00;
  wire [3:0] line_w, ready_w, done_w, busy_w;
  int tick_div = 1;
  int checks = 0, failures = 0;
  logic ln[4][256], dn[4][256], bz[4][256];
  typedef struct {
    logic [7:0] data;
    int         inst;
    logic [0:11] seq;
    int         nbits;
    int         frame;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  uart_tx_frame #(.PARITY_CHECK(0)) u_8n1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data), .i_tx_start(start),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_ready(ready_w[0]), .o_data(line_w[0]), .o_tx_done(done_w[0]), .o_busy(busy_w[0]));
  uart_tx_frame #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(1)) u_8e1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data), .i_tx_start(start),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_ready(ready_w[1]), .o_data(line_w[1]), .o_tx_done(done_w[1]), .o_busy(busy_w[1]));
  uart_tx_frame #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(0)) u_8o1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data), .i_tx_start(start),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_ready(ready_w[2]), .o_data(line_w[2]), .o_tx_done(done_w[2]), .o_busy(busy_w[2]));
  uart_tx_frame #(.N_DATA(7), .PARITY_CHECK(0), .M_STOP(2)) u_7n2 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data), .i_tx_start(start),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_ready(ready_w[3]), .o_data(line_w[3]), .o_tx_done(done_w[3]), .o_busy(busy_w[3]));

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      tick = (tick_div <= 1) || (ph == 0);
      ph = (ph + 1) % ((tick_div < 1) ? 1 : tick_div);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (ready_w != 4'hf && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("ready_timeout", int'(ready_w), 15);
  endtask

  task automatic send(input logic [7:0] d);
    wait_idle();
    start = 1'b1;
    data = d;
    @(posedge clk);
  endtask

  task automatic capture(input int n, input int pulse_at, input int brk_at);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
      if (t == pulse_at) begin
        start = 1'b1;
        data = 8'h00;
      end
      if (t == pulse_at + 1) start = 1'b0;
      if (t == brk_at) brk = 1'b1;
      for (int i = 0; i < 4; i++) begin
        ln[i][t] = line_w[i];
        dn[i][t] = done_w[i];
        bz[i][t] = busy_w[i];
      end
    end
  endtask

  function automatic int line_errs(input int i, input logic [0:11] seq, input int nbits);
    int e;
    e = 0;
    for (int t = 0; t < 16 * nbits; t++) if (ln[i][t] !== seq[t / 16]) e++;
    return e;
  endfunction

  initial begin
    int n, hi, lo, fd, nd, nb, post, sel;
    tbl[0] = '{8'hA5, 0, 12'b010100101111, 10, 160};
    tbl[1] = '{8'h07, 1, 12'b011100000111, 11, 176};
    tbl[2] = '{8'hA5, 2, 12'b010100101111, 11, 176};
    tbl[3] = '{8'hA5, 1, 12'b010100101011, 11, 176};
    tbl[4] = '{8'hFF, 3, 12'b011111111111, 10, 160};
    tbl[5] = '{8'h80, 3, 12'b000000001111, 10, 160};
    tbl[6] = '{8'h00, 2, 12'b000000000111, 11, 176};
    tbl[7] = '{8'h3C, 0, 12'b000111100111, 10, 160};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_line", int'(line_w), 15);
    chk("reset_ready", int'(ready_w), 15);
    chk("reset_done", int'(done_w), 0);
    chk("reset_busy", int'(busy_w), 0);

    for (int r = 0; r < 8; r++) begin
      send(tbl[r].data);
      capture(200, -1, -1);
      for (int j = 0; j < tbl[r].nbits; j++) begin
        sel = 16 * j + 8;
        for (int t = 16 * j; t < 16 * j + 16; t++) if (ln[tbl[r].inst][t] !== tbl[r].seq[j]) sel = t;
        chk($sformatf("row%0d_bit%0d", r, j), int'(ln[tbl[r].inst][sel]), int'(tbl[r].seq[j]));
      end
      fd = -1; nd = 0; nb = 0; post = 0;
      for (int t = 0; t < 200; t++) begin
        if (dn[tbl[r].inst][t]) begin
          nd++;
          if (fd < 0) fd = t;
        end
        if (bz[tbl[r].inst][t]) nb++;
        if (t >= tbl[r].frame && ln[tbl[r].inst][t] !== 1'b1) post++;
      end
      chk($sformatf("row%0d_done_at", r), fd, tbl[r].frame);
      chk($sformatf("row%0d_done_pulses", r), nd, 1);
      chk($sformatf("row%0d_busy_len", r), nb, tbl[r].frame);
      chk($sformatf("row%0d_idle_after", r), post, 0);
    end

    // Back-to-back with a mid-frame request that must be ignored.
    send(8'hA5);
    capture(161, 50, -1);
    chk("b2b_first_line_errs", line_errs(0, tbl[0].seq, 10), 0);
    chk("b2b_first_done", int'(dn[0][160]), 1);
    start = 1'b1;
    data = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_start_low", int'(line_w[0]), 0);
    chk("b2b_busy", int'(busy_w[0]), 1);
    n = 0;
    while (line_w[0] === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_start_len", n, 16);
    wait_idle();

    // Tick every third clock: each data bit spans 48 clocks; then reset mid-DATA.
    tick_div = 3;
    send(8'h55);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (line_w[0] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (line_w[0] === 1'b1 && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (line_w[0] === 1'b0 && lo < 400) begin
      lo++;
      @(negedge clk);
    end
    chk("div3_bit0_len", hi, 48);
    chk("div3_bit1_len", lo, 48);
    chk("div3_in_frame", int'(busy_w[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_line", int'(line_w), 15);
    chk("midrst_ready", int'(ready_w), 15);
    chk("midrst_busy", int'(busy_w), 0);
    chk("midrst_done", int'(done_w), 0);
    rst = 1'b0;
    nd = 0;
    repeat (600) begin
      @(negedge clk);
      if (done_w != 4'h0) nd++;
    end
    chk("midrst_no_done", nd, 0);
    tick_div = 1;

`ifdef UART_TX_BREAK_EN
    wait_idle();
    brk = 1'b1;
    @(negedge clk);
    chk("brk_idle_line", int'(line_w), 0);
    chk("brk_idle_ready", int'(ready_w), 0);
    brk = 1'b0;
    repeat (2) @(negedge clk);
    chk("brk_release_line", int'(line_w), 15);
    send(8'hA5);
    capture(161, -1, 40);
    chk("brk_frame_line_errs", line_errs(0, tbl[0].seq, 10), 0);
    chk("brk_frame_done", int'(dn[0][160]), 1);
    @(negedge clk);
    chk("brk_after_line", int'(line_w[0]), 0);
    chk("brk_after_ready", int'(ready_w[0]), 0);
    brk = 1'b0;
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises one parallel word per frame onto a single line.
- Frame: start bit, N_DATA data bits LSB-first, optional parity bit, M_STOP stop bits.
- Bit timing comes from an external oversampling tick (baud × OVERSAMPLE), shared with the UART receiver.
- Sits between the host/ALU interface logic and the board TX pin; a valid/ready handshake replaces the plain start strobe.

Parameters:
- NB_DATA, 8: width of i_data.
- N_DATA, 8: data bits sent per frame; 5..NB_DATA; bits above N_DATA-1 are ignored.
- PARITY_CHECK, 1: 1 inserts a parity bit, 0 omits it.
- EVEN_ODD_PARITY, 1: 1 even, 0 odd.
- M_STOP, 1: stop bits; 1..4.
- OVERSAMPLE, 16: ticks per bit; ≥2.

Ports:
- i_clock, in, 1: system clock.
- i_reset, in, 1: synchronous active-high reset.
- i_tick, in, 1: one-cycle oversampling tick; all bit timing advances only on it.
- i_data, in, NB_DATA: word to send.
- i_tx_start, in, 1: request valid.
- o_ready, out, 1: block accepts a request this cycle.
- o_data, out, 1: serial line; idle high.
- o_tx_done, out, 1: one-cycle pulse at end of frame.
- o_busy, out, 1: frame in progress.

Behaviour:
- Reset values: o_data=1, o_ready=1, o_tx_done=0, o_busy=0, state=IDLE, counters=0.
- States: IDLE, START, DATA, PARITY, STOP. All outputs registered.
- IDLE:
  - o_ready=1.
  - On i_tx_start&o_ready: latch i_data[N_DATA-1:0] into shift register, compute parity, enter START next cycle.
  - o_data goes 0 one clock after acceptance; o_busy=1 from the same edge.
- Request gating: i_tx_start while not ready is ignored (no queueing); i_data is don't-care outside the accept cycle.
- Tick counter: counts i_tick 0..OVERSAMPLE-1, cleared on every state entry. A bit ends on the tick where the count reaches OVERSAMPLE-1. Clocks without i_tick hold all state.
- START: o_data=0 for OVERSAMPLE ticks → DATA.
- DATA:
  - o_data=shift[0]; shift right at each bit end.
  - Bit counter 0..N_DATA-1.
  - After bit N_DATA-1 → PARITY if PARITY_CHECK, else STOP.
- PARITY: o_data = ^data (even) or ~^data (odd), over the N_DATA latched bits → STOP after OVERSAMPLE ticks.
- STOP:
  - o_data=1 for M_STOP×OVERSAMPLE ticks (stop counter × tick counter).
  - On the last tick: o_tx_done=1 for one clock, next state IDLE, o_busy=0, o_ready=1 on the same edge.
- Back-to-back: a request accepted in the first IDLE cycle starts the next start bit with zero idle-bit gap.
- Frame length: (1+N_DATA+PARITY_CHECK+M_STOP)×OVERSAMPLE ticks.
- Reset mid-frame: next edge returns to reset values; no o_tx_done.
- i_tick and accept in the same IDLE cycle: that tick is not counted in START.

Optional Feature:
UART_TX_BREAK_EN:
- Defined:
  - Adds input i_break (1 bit).
  - While i_break=1 in IDLE: o_data=0, o_ready=0.
  - i_break asserted during a frame takes effect only after the frame completes (after o_tx_done).
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Package uart_pkg:
  - NB_STATE and state encodings (shared with the receiver).
  - Parity-mode constants.
  - clog2-based width constants for tick, bit and stop counters.
- One sub-module, uart_bit_timer:
  - Tick counter with clear and terminal-count output, parametrised by OVERSAMPLE.
  - Reusable by the receiver for mid-bit sampling.

Test Plan:
- 8N1, OVERSAMPLE=16, i_tick every clock, send 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each 16 clocks; o_tx_done at clock 160 after accept.
- 8E1, send 0x07 → parity bit 1; 8O1, send 0xA5 → parity bit 1; 8E1, send 0xA5 → parity 0.
- 7N2, send 0xFF → 7 ones, then stop high for 32 ticks; bit 7 never appears; frame = 160 ticks.
- Two requests, second held on the o_tx_done cycle → second start bit begins immediately, o_data never idles between frames; i_tx_start pulsed mid-frame → ignored.
- i_tick every 3rd clock, 8N1 → each bit 48 clocks; i_reset asserted mid-DATA → o_data=1, o_ready=1 next edge, no o_tx_done.
- UART_TX_BREAK_EN, i_break=1 in IDLE → o_data=0, o_ready=0; i_break raised mid-frame → frame completes normally, then line goes low.
